// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one fixed-latency memory port between the instruction-fetch
//   requester (IF) and the data-memory requester (D). An IDLE/BUSY/RESP FSM
//   grants one access at a time, holds the memory-side signals stable for
//   MEM_LAT cycles, captures read data in the last busy cycle and returns a
//   one-cycle ready pulse to the owner. ostall feeds the hazard logic.
//
//   Optional feature macro: ROUND_ROBIN_EN
//     defined   : on a tie in IDLE the grant goes to the requester not granted
//                 last (last-grant register resets to IF, so D wins the first tie)
//     undefined : D has fixed priority over IF
//
// Ports
//   iclk, irst                  clock, synchronous active-high reset
//   if_req/if_addr              fetch request (held until if_ready) and address
//   iflush                      squash pending fetch response (branch taken)
//   if_rdata/if_ready           fetched instruction, one-cycle completion pulse
//   dm_req/dm_we/dm_addr        data request, store flag, address
//   dm_wdata/dm_be              store data, byte enables
//   dm_rdata/dm_ready           load data (registered), one-cycle completion pulse
//   mem_req/mem_we/mem_addr     memory port control and address
//   mem_wdata/mem_be/mem_rdata  memory write data, byte enables, read data
//   ostall                      requester waiting: (if_req&~if_ready)|(dm_req&~dm_ready)
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                iflush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                ostall
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } stateT;

    stateT              state;
    logic [CNT_W-1:0]   waitCnt;
    logic               ownerD;     // 1 = data requester owns the port
    logic               squash;     // fetch response must be dropped
    logic [ADDR_W-1:0]  addrQ;
    logic               weQ;
    logic [DATA_W-1:0]  wdataQ;
    logic [BE_W-1:0]    beQ;
    logic [DATA_W-1:0]  fetchBuf;   // fetch data waiting for the RESP cycle
    logic [DATA_W-1:0]  ifRdataQ;   // last delivered instruction
    logic [DATA_W-1:0]  dmRdataQ;
`ifdef ROUND_ROBIN_EN
    logic               lastGrantD;
`endif

    logic grantD;
    logic grantI;
    logic busy;
    logic ifDeliver;

    always_comb begin
`ifdef ROUND_ROBIN_EN
        grantD = dm_req & (~if_req | ~lastGrantD);
`else
        grantD = dm_req;
`endif
        grantI = if_req & ~grantD;
    end

    assign busy = (state == BUSY);

    // A flush arriving in the RESP cycle itself must still hide the fetch, so
    // the fetch result is staged in fetchBuf and only exposed (and committed to
    // ifRdataQ) when the RESP cycle is not squashed.
    assign ifDeliver = (state == RESP) & ~ownerD & ~squash & ~iflush;

    assign mem_req   = busy;
    assign mem_we    = busy & weQ;
    assign mem_addr  = busy ? addrQ  : '0;
    assign mem_wdata = busy ? wdataQ : '0;
    assign mem_be    = busy ? beQ    : '0;

    assign if_ready  = ifDeliver;
    assign if_rdata  = ifDeliver ? fetchBuf : ifRdataQ;
    assign dm_ready  = (state == RESP) & ownerD;
    assign dm_rdata  = dmRdataQ;

    assign ostall    = (if_req & ~if_ready) | (dm_req & ~dm_ready);

    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= IDLE;
            waitCnt    <= '0;
            ownerD     <= 1'b0;
            squash     <= 1'b0;
            addrQ      <= '0;
            weQ        <= 1'b0;
            wdataQ     <= '0;
            beQ        <= '0;
            fetchBuf   <= '0;
            ifRdataQ   <= '0;
            dmRdataQ   <= '0;
`ifdef ROUND_ROBIN_EN
            lastGrantD <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    squash <= 1'b0;
                    if (grantD | grantI) begin
                        ownerD  <= grantD;
                        addrQ   <= grantD ? dm_addr  : if_addr;
                        weQ     <= grantD & dm_we;
                        wdataQ  <= grantD ? dm_wdata : '0;
                        beQ     <= grantD ? dm_be    : '1;
                        waitCnt <= '0;
                        state   <= BUSY;
`ifdef ROUND_ROBIN_EN
                        lastGrantD <= grantD;
`endif
                    end
                end
                BUSY: begin
                    waitCnt <= waitCnt + 1'b1;
                    if (iflush & ~ownerD) begin
                        squash <= 1'b1;
                    end
                    if (waitCnt == CNT_LAST) begin
                        if (ownerD) begin
                            if (!weQ) begin
                                dmRdataQ <= mem_rdata;
                            end
                        end else begin
                            fetchBuf <= mem_rdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (ifDeliver) begin
                        ifRdataQ <= fetchBuf;
                    end
                    squash <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single shared memory port between the pipeline's instruction-fetch requester (IF) and the data-memory requester (MEM stage load/store). Runs a small FSM plus a wait-state counter to sequence fixed-latency accesses. Returns registered read data with one-cycle ready pulses, and produces a pipeline stall indication for the hazard logic. Sits between the pipelined core and the unified instruction/data memory.

Parameters:
ADDR_W, 32, address width of requesters and memory port
DATA_W, 32, data width
MEM_LAT, 2, memory latency in cycles (>=1); mem_rdata is valid in the last cycle of a busy window

Ports:
iclk  input  1  clock
irst  input  1  synchronous active-high reset
if_req  input  1  instruction fetch request, held until if_ready
if_addr  input  ADDR_W  fetch address
iflush  input  1  squash pending/next fetch response (branch taken)
if_rdata  output  DATA_W  fetched instruction (registered)
if_ready  output  1  one-cycle fetch completion pulse
dm_req  input  1  data request, held until dm_ready
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  store data
dm_be  input  DATA_W/8  byte enables
dm_rdata  output  DATA_W  load data (registered)
dm_ready  output  1  one-cycle data completion pulse
mem_req  output  1  memory access active
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_be  output  DATA_W/8  memory byte enables
mem_rdata  input  DATA_W  memory read data
ostall  output  1  (if_req & ~if_ready) | (dm_req & ~dm_ready)

Behaviour:
- Reset: state IDLE, counter 0, all mem_* outputs 0, if_rdata/dm_rdata 0, if_ready/dm_ready 0, owner flag 0, squash flag 0.
- States: IDLE, BUSY, RESP.
- IDLE: if dm_req, grant D; else if if_req, grant I; else stay. On grant, latch owner, addr, we (I: we=0, be=all ones), wdata and be into registers; counter <= 0; go BUSY.
- BUSY: mem_req=1. mem_we/addr/wdata/be driven from the latched registers only, stable across the whole window. Counter increments each cycle. At counter==MEM_LAT-1, capture mem_rdata into owner's rdata register (loads and fetches only; stores leave dm_rdata unchanged), then go RESP.
- RESP: mem_req=0. Pulse owner's ready for exactly one cycle. No grant in this cycle. Next state IDLE.
- Timing: request sampled in IDLE at cycle 0, BUSY cycles 1..MEM_LAT, ready in cycle MEM_LAT+1, earliest next grant in cycle MEM_LAT+2. Throughput is one access per MEM_LAT+2 cycles.
- Requester dropping req mid-transaction: access still completes and the ready pulse is still issued.
- iflush: if asserted while owner=I in BUSY or RESP, set squash flag. In RESP, if squash flag or iflush is set, suppress if_ready and leave if_rdata unchanged. Squash clears on return to IDLE. iflush in IDLE has no effect. iflush never affects data accesses.
- ostall is combinational from current req/ready.
- Reset mid-operation: abort immediately to IDLE. mem_req drops the next cycle. No ready pulse is produced.

Optional Feature:
ROUND_ROBIN_EN: when defined, if both requests are present in IDLE, the grant goes to the requester not granted last. A last-grant register resets to I, so D wins the first tie. When undefined, D has fixed priority, and a continuous dm_req may starve IF.

Test Plan:
- MEM_LAT=2, load dm_req=1, addr=0x100, mem_rdata=0xDEADBEEF in cycle 2 -> mem_req high cycles 1-2, dm_ready=1 in cycle 3 with dm_rdata=0xDEADBEEF, mem_req=0 in cycle 3.
- Store dm_we=1, addr=0x20, wdata=0x12345678, be=4'b0011 -> mem_we=1, mem_be=0011, mem_wdata stable cycles 1-2; dm_ready cycle 3; dm_rdata unchanged.
- if_req and dm_req both high in cycle 0 -> without ROUND_ROBIN_EN: D served (ready cycle 3), I granted cycle 4, if_ready cycle 7. With ROUND_ROBIN_EN and repeated ties: grants alternate D, I, D.
- Fetch in progress, iflush=1 in cycle 2 -> no if_ready pulse, if_rdata keeps old value, next grant possible cycle 4.
- irst=1 in cycle 1 of a busy load -> cycle 2: mem_req=0, dm_ready never pulses, state IDLE; re-issued request completes normally.
